// File: rtl/pc_trace_pkg.sv
// Shared defaults and types for the memory-access trace buffer.
package pc_trace_pkg;

  localparam int DEF_DEPTH = 16;
  localparam int DEF_AW    = 32;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_LW    = $clog2(DEF_DEPTH) + 1;

  localparam logic [DEF_CNT_W-1:0] CNT_MAX = {DEF_CNT_W{1'b1}};

  typedef logic [DEF_AW-1:0] trace_adr_t;

endpackage

// File: rtl/pc_trace_buf_if.sv
// Capture, stream and status signals of the trace buffer; slave is the buffer side.
interface pc_trace_buf_if
  import pc_trace_pkg::*;
#(
  parameter int AW    = DEF_AW,
  parameter int CNT_W = DEF_CNT_W,
  parameter int LW    = DEF_LW
);

  logic [AW-1:0]    i_adr;
  logic             i_vld;
  logic             i_clear;
  logic [AW-1:0]    o_data;
  logic             o_valid;
  logic             i_ready;
  logic [LW-1:0]    o_level;
  logic             o_overflow;
  logic [CNT_W-1:0] o_drop_cnt;

  modport slave (
    input  i_adr, i_vld, i_clear, i_ready,
    output o_data, o_valid, o_level, o_overflow, o_drop_cnt
  );

  modport master (
    output i_adr, i_vld, i_clear, i_ready,
    input  o_data, o_valid, o_level, o_overflow, o_drop_cnt
  );

endinterface

// File: rtl/pc_trace_fifo.sv
// Generic first-word-fall-through synchronous FIFO with a registered head word.
module pc_trace_fifo
  import pc_trace_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int W     = DEF_AW,
  parameter int PW    = $clog2(DEPTH),
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          valid,
  output logic [LW-1:0] level,
  output logic          full
);

  localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);
  localparam logic [LW-1:0] LVL_ZERO = {LW{1'b0}};
  localparam logic [LW-1:0] LVL_ONE  = LW'(1'b1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] wptr_r;
  logic [PW-1:0] rptr_r;
  logic [LW-1:0] level_r;
  logic [W-1:0]  data_r;
  logic          valid_r;

  logic          full_s;
  logic          wr_s;
  logic          rd_s;
  logic [PW-1:0] rptr_inc_s;
  logic [LW-1:0] level_nxt_s;
  logic [W-1:0]  head_nxt_s;

  assign full_s     = (level_r == LVL_FULL);
  assign rd_s       = pop && valid_r && !clear;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr_s       = push && !clear && (!full_s || rd_s);
  assign rptr_inc_s = rptr_r + PTR_ONE;

  // Occupancy after this cycle's write/read.
  always_comb begin
    level_nxt_s = level_r;
    case ({wr_s, rd_s})
      2'b10:   level_nxt_s = level_r + LVL_ONE;
      2'b01:   level_nxt_s = level_r - LVL_ONE;
      default: level_nxt_s = level_r;
    endcase
  end

  // Next head word: the incoming word when it lands in an empty slot, else the next stored entry.
  always_comb begin
    head_nxt_s = data_r;
    if (level_r == LVL_ZERO) begin
      if (wr_s) begin
        head_nxt_s = wdata;
      end else begin
        head_nxt_s = data_r;
      end
    end else if (rd_s) begin
      if (level_r == LVL_ONE) begin
        if (wr_s) begin
          head_nxt_s = wdata;
        end else begin
          head_nxt_s = data_r;
        end
      end else begin
        head_nxt_s = mem_r[rptr_inc_s];
      end
    end else begin
      head_nxt_s = data_r;
    end
  end

  // Storage array, deliberately without reset.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_r[wptr_r] <= wdata;
    end
  end

  // Pointers, occupancy and registered head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r  <= {PW{1'b0}};
      rptr_r  <= {PW{1'b0}};
      level_r <= LVL_ZERO;
      data_r  <= {W{1'b0}};
      valid_r <= 1'b0;
    end else if (clear) begin
      wptr_r  <= {PW{1'b0}};
      rptr_r  <= {PW{1'b0}};
      level_r <= LVL_ZERO;
      valid_r <= 1'b0;
    end else begin
      if (wr_s) begin
        wptr_r <= wptr_r + PTR_ONE;
      end
      if (rd_s) begin
        rptr_r <= rptr_inc_s;
      end
      level_r <= level_nxt_s;
      data_r  <= head_nxt_s;
      valid_r <= (level_nxt_s != LVL_ZERO);
    end
  end

  assign rdata = data_r;
  assign valid = valid_r;
  assign level = level_r;
  assign full  = full_s;

endmodule

// File: rtl/pc_trace_buf.sv
// Trace capture buffer: FWFT FIFO plus drop accounting on the stream interface.
// Optional duplicate-address filter enabled by defining PC_TRACE_DEDUP_EN.
module pc_trace_buf
  import pc_trace_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic           wb_clk,
  input  logic           wb_rst_n,
  pc_trace_buf_if.slave  trc
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_TOP = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  logic          cand_s;
  logic          pop_s;
  logic          full_s;
  logic          drop_s;
  logic [AW-1:0] fifo_data_s;
  logic          fifo_valid_s;
  logic [LW-1:0] fifo_level_s;

  logic             overflow_r;
  logic [CNT_W-1:0] drop_cnt_r;

`ifdef PC_TRACE_DEDUP_EN
  logic [AW-1:0] last_adr_r;
  logic          last_vld_r;

  assign cand_s = trc.i_vld && !(last_vld_r && (trc.i_adr == last_adr_r));

  // Remember the latest capture address, whether or not it reached the FIFO.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      last_adr_r <= {AW{1'b0}};
      last_vld_r <= 1'b0;
    end else if (trc.i_clear) begin
      last_vld_r <= 1'b0;
    end else if (trc.i_vld) begin
      last_adr_r <= trc.i_adr;
      last_vld_r <= 1'b1;
    end else begin
      last_vld_r <= last_vld_r;
    end
  end
`else
  assign cand_s = trc.i_vld;
`endif

  assign pop_s  = fifo_valid_s && trc.i_ready;
  assign drop_s = cand_s && full_s && !pop_s && !trc.i_clear;

  pc_trace_fifo #(
    .DEPTH (DEPTH),
    .W     (AW)
  ) u_fifo (
    .clk   (wb_clk),
    .rst_n (wb_rst_n),
    .clear (trc.i_clear),
    .push  (cand_s),
    .pop   (pop_s),
    .wdata (trc.i_adr),
    .rdata (fifo_data_s),
    .valid (fifo_valid_s),
    .level (fifo_level_s),
    .full  (full_s)
  );

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      overflow_r <= 1'b0;
      drop_cnt_r <= {CNT_W{1'b0}};
    end else if (trc.i_clear) begin
      overflow_r <= 1'b0;
      drop_cnt_r <= {CNT_W{1'b0}};
    end else if (drop_s) begin
      overflow_r <= 1'b1;
      if (drop_cnt_r != CNT_TOP) begin
        drop_cnt_r <= drop_cnt_r + CNT_ONE;
      end
    end else begin
      overflow_r <= overflow_r;
    end
  end

  assign trc.o_data     = fifo_data_s;
  assign trc.o_valid    = fifo_valid_s;
  assign trc.o_level    = fifo_level_s;
  assign trc.o_overflow = overflow_r;
  assign trc.o_drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_pc_trace_buf.sv
// Directed self-checking bench for pc_trace_buf (DEPTH=16, AW=32, CNT_W=16).
module tb_pc_trace_buf;
  import pc_trace_pkg::*;

  logic wb_clk;
  logic wb_rst_n;
  int   n_tests;
  int   n_fail;

  pc_trace_buf_if #(.AW(32), .CNT_W(16), .LW(5)) trc ();

  pc_trace_buf #(.DEPTH(16), .AW(32), .CNT_W(16)) dut (
    .wb_clk   (wb_clk),
    .wb_rst_n (wb_rst_n),
    .trc      (trc)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    trace_adr_t a;
    n_tests = 0;
    n_fail  = 0;
    trc.i_adr   = 32'h0;
    trc.i_vld   = 1'b0;
    trc.i_clear = 1'b0;
    trc.i_ready = 1'b0;
    wb_rst_n    = 1'b0;

    // Reset state
    #12;
    chk("rst_valid", trc.o_valid, 64'd0);
    chk("rst_level", trc.o_level, 64'd0);
    chk("rst_ovf",   trc.o_overflow, 64'd0);
    chk("rst_drop",  trc.o_drop_cnt, 64'd0);
    chk("rst_data",  trc.o_data, 64'd0);
    wb_rst_n = 1'b1;
    tick();

    // Single capture, held while not ready, then popped
    trc.i_vld = 1'b1; trc.i_adr = 32'h0000_0100;
    tick();
    trc.i_vld = 1'b0;
    chk("single_valid", trc.o_valid, 64'd1);
    chk("single_data",  trc.o_data, 64'h100);
    chk("single_level", trc.o_level, 64'd1);
    tick();
    chk("hold_valid", trc.o_valid, 64'd1);
    chk("hold_data",  trc.o_data, 64'h100);
    trc.i_ready = 1'b1;
    tick();
    trc.i_ready = 1'b0;
    chk("single_pop_valid", trc.o_valid, 64'd0);
    chk("single_pop_level", trc.o_level, 64'd0);

    // Fill with 20 captures: 16 stored, 4 dropped
    for (int i = 0; i < 20; i++) begin
      trc.i_vld = 1'b1; trc.i_adr = 32'(i * 4);
      tick();
    end
    trc.i_vld = 1'b0;
    chk("fill_level", trc.o_level, 64'd16);
    chk("fill_ovf",   trc.o_overflow, 64'd1);
    chk("fill_drop",  trc.o_drop_cnt, 64'd4);
    trc.i_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", trc.o_data, 64'(i * 4));
      tick();
    end
    trc.i_ready = 1'b0;
    chk("drain_valid", trc.o_valid, 64'd0);
    chk("drain_level", trc.o_level, 64'd0);
    chk("drain_ovf_sticky", trc.o_overflow, 64'd1);
    chk("drain_drop_kept",  trc.o_drop_cnt, 64'd4);

    // Clear status, then full with simultaneous pop
    trc.i_clear = 1'b1;
    tick();
    trc.i_clear = 1'b0;
    chk("clr_ovf",  trc.o_overflow, 64'd0);
    chk("clr_drop", trc.o_drop_cnt, 64'd0);
    for (int i = 0; i < 16; i++) begin
      trc.i_vld = 1'b1; trc.i_adr = 32'(i * 4);
      tick();
    end
    trc.i_vld = 1'b0;
    chk("full_level", trc.o_level, 64'd16);
    trc.i_vld = 1'b1; trc.i_adr = 32'h40; trc.i_ready = 1'b1;
    tick();
    trc.i_vld = 1'b0; trc.i_ready = 1'b0;
    chk("fullpop_drop",  trc.o_drop_cnt, 64'd0);
    chk("fullpop_ovf",   trc.o_overflow, 64'd0);
    chk("fullpop_level", trc.o_level, 64'd16);
    chk("fullpop_head",  trc.o_data, 64'h4);
    trc.i_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      chk("fullpop_drain", trc.o_data, 64'(i * 4));
      tick();
    end
    trc.i_ready = 1'b0;
    chk("fullpop_empty", trc.o_level, 64'd0);

    // Clear priority: 3 entries, 2 drops, clear with coincident capture
    for (int i = 0; i < 18; i++) begin
      trc.i_vld = 1'b1; trc.i_adr = 32'(i * 4);
      tick();
    end
    trc.i_vld = 1'b0;
    trc.i_ready = 1'b1;
    for (int i = 0; i < 13; i++) tick();
    trc.i_ready = 1'b0;
    chk("pre_clr_level", trc.o_level, 64'd3);
    chk("pre_clr_drop",  trc.o_drop_cnt, 64'd2);
    chk("pre_clr_head",  trc.o_data, 64'h34);
    trc.i_clear = 1'b1; trc.i_vld = 1'b1; trc.i_adr = 32'h999;
    tick();
    trc.i_clear = 1'b0; trc.i_vld = 1'b0;
    chk("clrp_level", trc.o_level, 64'd0);
    chk("clrp_valid", trc.o_valid, 64'd0);
    chk("clrp_ovf",   trc.o_overflow, 64'd0);
    chk("clrp_drop",  trc.o_drop_cnt, 64'd0);
    tick();
    chk("clrp_discard", trc.o_level, 64'd0);

    // Asynchronous reset between edges
    trc.i_vld = 1'b1; trc.i_adr = 32'h200;
    tick();
    trc.i_vld = 1'b0;
    chk("arst_pre_valid", trc.o_valid, 64'd1);
    trc.i_ready = 1'b1;
    #2;
    wb_rst_n = 1'b0;
    #1;
    chk("arst_valid", trc.o_valid, 64'd0);
    chk("arst_level", trc.o_level, 64'd0);
    chk("arst_data",  trc.o_data, 64'd0);
    trc.i_ready = 1'b0;
    #3;
    wb_rst_n = 1'b1;
    tick();
    chk("arst_after_level", trc.o_level, 64'd0);

    // Repeated-address captures
    a = 32'h10; trc.i_vld = 1'b1; trc.i_adr = a; tick();
    trc.i_adr = 32'h10; tick();
    trc.i_adr = 32'h14; tick();
    trc.i_adr = 32'h10; tick();
    trc.i_vld = 1'b0;
`ifdef PC_TRACE_DEDUP_EN
    chk("dedup_level", trc.o_level, 64'd3);
    trc.i_ready = 1'b1;
    chk("dedup_d0", trc.o_data, 64'h10); tick();
    chk("dedup_d1", trc.o_data, 64'h14); tick();
    chk("dedup_d2", trc.o_data, 64'h10); tick();
`else
    chk("dedup_level", trc.o_level, 64'd4);
    trc.i_ready = 1'b1;
    chk("dedup_d0", trc.o_data, 64'h10); tick();
    chk("dedup_d1", trc.o_data, 64'h10); tick();
    chk("dedup_d2", trc.o_data, 64'h14); tick();
    chk("dedup_d3", trc.o_data, 64'h10); tick();
`endif
    trc.i_ready = 1'b0;
    chk("dedup_empty", trc.o_valid, 64'd0);
    chk("dedup_drop",  trc.o_drop_cnt, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_trace_buf.md
Name: pc_trace_buf

Overview:
- Downstream consumer of the simulation SoC's memory-access trace (bus address plus ack strobe).
- Captures each acknowledged address into a synchronous first-word-fall-through FIFO.
- Presents captured addresses on a valid/ready stream to a trace dumper or compare checker.
- Counts and flags addresses lost when the FIFO is full, so benches can detect an incomplete trace.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- AW, 32, address width captured per entry.
- CNT_W, 16, width of the dropped-entry counter.

Ports:
- wb_clk  in  1  sole clock; all logic rising-edge.
- wb_rst_n  in  1  asynchronous active-low reset.
- i_adr  in  AW  trace address (bus address).
- i_vld  in  1  capture strobe (bus ack); one capture per high cycle.
- i_clear  in  1  synchronous flush of FIFO and status.
- o_data  out  AW  head-of-FIFO address.
- o_valid  out  1  FIFO non-empty.
- i_ready  in  1  consumer accepts o_data this cycle.
- o_level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- o_overflow  out  1  sticky: at least one capture dropped since reset/clear.
- o_drop_cnt  out  CNT_W  number of dropped captures, saturating.

Behaviour:
- Reset (wb_rst_n low, asynchronous) sets:
  - read/write pointers to 0, o_level=0, o_valid=0;
  - o_overflow=0, o_drop_cnt=0, o_data=0.
  - Storage array is not reset.
- push = i_vld (gated by dedup when enabled). pop = o_valid && i_ready.
- FWFT: o_data is always the oldest entry. When empty, o_data holds its last value and is don't-care.
- Latency: capture in cycle N gives o_valid=1 and o_data=i_adr in cycle N+1 when the FIFO was empty.
- Push while not full: write at wptr, wptr wraps mod DEPTH, level+1.
- Push while full:
  - If pop is asserted the same cycle, both are accepted and level stays DEPTH.
  - Otherwise the address is dropped, o_overflow is set, and o_drop_cnt increments, saturating at 2^CNT_W-1.
- Pop while empty is impossible, because o_valid=0.
- Push and pop together while not full: level unchanged, both pointers advance.
- Pointer wrap: pointers are log2(DEPTH) bits wide and wrap naturally. Full/empty are derived from o_level, not from pointer compare.
- i_clear has priority over push and pop in the same cycle:
  - pointers and level go to 0;
  - o_overflow and o_drop_cnt go to 0;
  - a coincident capture is discarded and is not counted as a drop.
- i_ready may toggle freely. o_data/o_valid must not change while o_valid && !i_ready, except on clear or reset.
- Reset asserted mid-stream discards all contents immediately, with no completion of an in-flight pop.

Optional Feature:
- Macro: PC_TRACE_DEDUP_EN.
- Defined:
  - A register last_adr (reset 0) plus a flag last_vld (reset 0) track the most recent push candidate.
  - A capture with last_vld && i_adr==last_adr is suppressed: no push, no drop count.
  - Each qualifying i_vld updates last_adr and sets last_vld, even if the push itself is dropped because the FIFO is full.
  - i_clear clears last_vld.
- Undefined: every i_vld cycle is a push candidate; no extra registers.

Decomposition:
- Package pc_trace_pkg:
  - default DEPTH/AW/CNT_W constants;
  - CNT_MAX localparam helper;
  - typedef for the address entry.
- Sub-module pc_trace_fifo:
  - generic FWFT sync FIFO with push/pop/clear and level output;
  - no drop logic.
- pc_trace_buf holds:
  - drop/overflow accounting;
  - the dedup filter;
  - the stream interface.

Test Plan:
- Single capture: i_vld=1, i_adr=0x0000_0100 with i_ready=0 -> next cycle o_valid=1, o_data=0x100, o_level=1; i_ready=1 one cycle -> o_valid=0, o_level=0.
- Fill and overflow (DEPTH=16): 20 back-to-back captures 0x0..0x4C step 4, i_ready=0 -> o_level=16, o_overflow=1, o_drop_cnt=4; drain yields 0x0..0x3C in order.
- Full with simultaneous pop: FIFO full with 0x0..0x3C, then i_vld=1 adr=0x40 with i_ready=1 -> o_drop_cnt unchanged, level stays 16, last entry drained is 0x40.
- Clear priority: FIFO holds 3 entries with o_drop_cnt=2; assert i_clear with i_vld=1 -> next cycle o_level=0, o_valid=0, o_overflow=0, o_drop_cnt=0.
- Async reset mid-stream: drop wb_rst_n between clock edges while o_valid=1 -> o_valid=0 and o_level=0 immediately, before the next edge.
- Dedup (PC_TRACE_DEDUP_EN): captures 0x10, 0x10, 0x14, 0x10 -> FIFO holds 0x10, 0x14, 0x10 (level 3). Without the macro, level is 4.
